// File: rtl/dmem_responder.sv
// dmem_responder: target end of the RV32I core's data-memory port.
// A synchronous word RAM with byte-lane writes, a configurable number of
// wait states, a one-cycle ready strobe and a fault flag for rejected
// accesses.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a read or write request; requests sampled here
// S_WAIT | access latched, wait-state down-counter running
// S_RESP | ready/fault/read-data presented for exactly one cycle
//
// Memory commit and read capture both occur on the edge that enters
// S_RESP. With no wait states that edge is the accept edge itself, so the
// "current access" fields are taken straight from the inputs while in
// S_IDLE and from the latched copies otherwise.

module dmem_responder #(
   parameter int          ADDR_WIDTH  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_data_out,
   input  logic        dmem_read_en,
   input  logic        dmem_write_en,
   input  logic [3:0]  dmem_byte_en,
   output logic [31:0] dmem_data_in,
   output logic        dmem_ready,
   output logic        dmem_fault,
   output logic [31:0] access_count
);

   localparam int         DEPTH     = 1 << ADDR_WIDTH;
   localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
   localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
   // Size of the mapped window in bytes, kept one bit wider than the address
   localparam logic [32:0] WINDOW_BYTES = 33'd1 << (ADDR_WIDTH + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state_q;
   logic [3:0]            wcnt_q;

   // access latched at accept
   logic [ADDR_WIDTH-1:0] acc_idx_q;
   logic [31:0]           acc_wdata_q;
   logic [3:0]            acc_be_q;
   logic                  acc_write_q;
   logic                  acc_fault_q;

   // registered outputs
   logic                  ready_q;
   logic                  resp_fault_q;
   logic [31:0]           rdata_q;
   logic [31:0]           count_q;

   logic [31:0]           mem_q [DEPTH];

   // request decode on the raw inputs
   logic                  req;
   logic [31:0]           in_off;
   logic                  in_be_ok;
   logic                  in_range_bad;
   logic                  in_fault;
   logic [ADDR_WIDTH-1:0] in_idx;

   // access currently being serviced
   logic                  in_idle;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [31:0]           cur_wdata;
   logic [3:0]            cur_be;
   logic                  cur_write;
   logic                  cur_fault;
   logic [31:0]           cur_mask;
   logic                  enter_resp;
   logic                  mem_we;
   logic [31:0]           rd_word;

   // Decode the incoming request and classify it as legal or faulting
   always_comb begin
      req    = dmem_read_en | dmem_write_en;
      in_off = dmem_addr - BASE_ADDR;
      in_idx = in_off[ADDR_WIDTH+1:2];
      case (dmem_byte_en)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: in_be_ok = 1'b1;
         default:                   in_be_ok = 1'b0;
      endcase
      in_range_bad = (dmem_addr < BASE_ADDR) || ({1'b0, in_off} >= WINDOW_BYTES);
      in_fault     = (dmem_read_en & dmem_write_en) | ~in_be_ok | in_range_bad;
   end

   // Select live inputs in IDLE (zero-wait path) or the latched access otherwise
   always_comb begin
      in_idle   = (state_q == S_IDLE);
      cur_idx   = in_idle ? in_idx        : acc_idx_q;
      cur_wdata = in_idle ? dmem_data_out : acc_wdata_q;
      cur_be    = in_idle ? dmem_byte_en  : acc_be_q;
      cur_write = in_idle ? dmem_write_en : acc_write_q;
      cur_fault = in_idle ? in_fault      : acc_fault_q;
      cur_mask  = {{8{cur_be[3]}}, {8{cur_be[2]}}, {8{cur_be[1]}}, {8{cur_be[0]}}};
      enter_resp = (in_idle && req && !HAS_WAIT) ||
                   ((state_q == S_WAIT) && (wcnt_q == 4'd0));
      // reset on the commit edge suppresses the write
      mem_we  = enter_resp && cur_write && !cur_fault && !reset;
      rd_word = mem_q[cur_idx] & cur_mask;
   end

   // Byte-lane write into the RAM; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) begin
               mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
         end
      end
   end

   // Sequencing FSM with registered response outputs and access counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wcnt_q       <= 4'd0;
         acc_idx_q    <= '0;
         acc_wdata_q  <= 32'd0;
         acc_be_q     <= 4'd0;
         acc_write_q  <= 1'b0;
         acc_fault_q  <= 1'b0;
         ready_q      <= 1'b0;
         resp_fault_q <= 1'b0;
         rdata_q      <= 32'd0;
         count_q      <= 32'd0;
      end else begin
         ready_q      <= 1'b0;
         resp_fault_q <= 1'b0;
         rdata_q      <= 32'd0;

         case (state_q)
            S_IDLE: begin
               if (req) begin
                  acc_idx_q   <= in_idx;
                  acc_wdata_q <= dmem_data_out;
                  acc_be_q    <= dmem_byte_en;
                  acc_write_q <= dmem_write_en;
                  acc_fault_q <= in_fault;
                  if (HAS_WAIT) begin
                     state_q <= S_WAIT;
                     wcnt_q  <= WAIT_LOAD;
                  end else begin
                     state_q <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               if (wcnt_q == 4'd0) begin
                  state_q <= S_RESP;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         if (enter_resp) begin
            ready_q      <= 1'b1;
            resp_fault_q <= cur_fault;
            rdata_q      <= (!cur_fault && !cur_write) ? rd_word : 32'd0;
            if (!cur_fault) begin
               count_q <= count_q + 32'd1;
            end
         end
      end
   end

   assign dmem_ready   = ready_q;
   assign dmem_fault   = resp_fault_q;
   assign dmem_data_in = rdata_q;
   assign access_count = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (no wait states, three wait
// states) driven with directed and randomized accesses and compared against
// an associative-array memory model with its own latency/fault rules.

module tb_dmem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic        re   [2];
   logic        we   [2];
   logic [3:0]  be   [2];
   logic [31:0] rdat [2];
   logic        rdy  [2];
   logic        flt  [2];
   logic [31:0] cnt  [2];

   dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .dmem_addr(addr[0]), .dmem_data_out(wd[0]),
      .dmem_read_en(re[0]), .dmem_write_en(we[0]), .dmem_byte_en(be[0]),
      .dmem_data_in(rdat[0]), .dmem_ready(rdy[0]), .dmem_fault(flt[0]),
      .access_count(cnt[0]));

   dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut1 (
      .clk(clk), .reset(rst[1]), .dmem_addr(addr[1]), .dmem_data_out(wd[1]),
      .dmem_read_en(re[1]), .dmem_write_en(we[1]), .dmem_byte_en(be[1]),
      .dmem_data_in(rdat[1]), .dmem_ready(rdy[1]), .dmem_fault(flt[1]),
      .access_count(cnt[1]));

   int          n_assert = 0;
   int          n_fail   = 0;
   int          ws_of [2] = '{0, 3};

   // reference model: word store keyed by instance and word index
   logic [31:0] mm [int];
   logic [31:0] cnt_m [2];
   logic [3:0]  legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0011, 4'b1100, 4'b1111};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_fault(input bit r, input bit w,
                                      input logic [31:0] a, input logic [3:0] b);
      bit be_ok = 1'b0;
      foreach (legal[i]) if (legal[i] == b) be_ok = 1'b1;
      // 4096 words of 4 bytes starting at byte 0
      return (r && w) || !be_ok || (a >= 32'h0000_4000);
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] b);
      logic [31:0] m = 32'd0;
      for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
      return m;
   endfunction

   task automatic idle_inputs(input int d);
      addr[d] = 32'd0; wd[d] = 32'd0; re[d] = 1'b0; we[d] = 1'b0; be[d] = 4'd0;
   endtask

   // One complete access: drive, wait for ready, check response, update model
   task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] data, input logic [3:0] b, input bit scramble);
      bit          f;
      int          key;
      int          lat;
      bit          seen;
      logic [31:0] expd;
      logic [31:0] tmp;
      f    = model_fault(r, w, a, b);
      key  = d * 8192 + int'(a[13:2]);
      expd = 32'd0;
      if (!f && r && mm.exists(key)) expd = mm[key] & lane_mask(b);

      @(negedge clk);
      addr[d] = a; wd[d] = data; re[d] = r; we[d] = w; be[d] = b;
      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= 24 && !seen; k++) begin
         @(negedge clk);
         if (rdy[d]) begin
            seen = 1'b1;
            lat  = k;
         end else if (scramble) begin
            addr[d] = $urandom; wd[d] = $urandom; be[d] = 4'($urandom);
         end
      end
      idle_inputs(d);
      chk($sformatf("d%0d latency a=%h", d, a), 32'(lat), 32'(1 + ws_of[d]));
      if (seen) begin
         chk($sformatf("d%0d fault a=%h be=%b", d, a, b), 32'(flt[d]), 32'(f));
         chk($sformatf("d%0d rdata a=%h be=%b", d, a, b), rdat[d], expd);
      end

      if (!f) begin
         cnt_m[d] = cnt_m[d] + 32'd1;
         if (w) begin
            tmp = mm.exists(key) ? mm[key] : 32'd0;
            for (int i = 0; i < 4; i++) if (b[i]) tmp[8*i +: 8] = data[8*i +: 8];
            mm[key] = tmp;
         end
      end

      @(negedge clk);
      chk($sformatf("d%0d ready single pulse", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("d%0d fault idle", d), 32'(flt[d]), 32'd0);
      chk($sformatf("d%0d data idle", d), rdat[d], 32'd0);
      chk($sformatf("d%0d count", d), cnt[d], cnt_m[d]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [3:0]  b;
      int          d;
      int          kind;

      for (int i = 0; i < 2; i++) begin
         idle_inputs(i);
         rst[i]   = 1'b1;
         cnt_m[i] = 32'd0;
      end

      // reset for two cycles, outputs all zero
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d reset ready", i), 32'(rdy[i]), 32'd0);
         chk($sformatf("d%0d reset fault", i), 32'(flt[i]), 32'd0);
         chk($sformatf("d%0d reset data", i), rdat[i], 32'd0);
         chk($sformatf("d%0d reset count", i), cnt[i], 32'd0);
         rst[i] = 1'b0;
      end
      @(negedge clk);

      // full-word write/read, byte write then halfword read, faults
      access(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'b1111, 0);
      access(0, 1, 0, 32'h40, 32'h0,        4'b1111, 0);
      access(0, 0, 1, 32'h44, 32'h11223344, 4'b1111, 0);
      access(0, 0, 1, 32'h45, 32'h0000AA00, 4'b0010, 0);
      access(0, 1, 0, 32'h44, 32'h0,        4'b1100, 0);
      access(0, 0, 1, 32'h44, 32'hFFFFFFFF, 4'b0101, 0);
      access(0, 1, 1, 32'h44, 32'h55555555, 4'b1111, 0);
      access(0, 0, 1, 32'h4000, 32'h77777777, 4'b1111, 0);
      access(0, 1, 0, 32'h44, 32'h0,        4'b1111, 0);
      access(0, 1, 0, 32'hFFC, 32'h0,       4'b1000, 0);

      // wait states with inputs scrambled while waiting
      access(1, 0, 1, 32'h80, 32'hCAFEF00D, 4'b1111, 1);
      access(1, 1, 0, 32'h80, 32'h0,        4'b1111, 1);

      // reset during WAIT, asserted across the commit edge
      @(negedge clk);
      addr[1] = 32'h80; wd[1] = 32'h12345678; we[1] = 1'b1; be[1] = 4'b1111;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("d1 no ready before reset k=%0d", k), 32'(rdy[1]), 32'd0);
      end
      rst[1] = 1'b1;
      idle_inputs(1);
      @(negedge clk);
      chk("d1 no ready at aborted commit", 32'(rdy[1]), 32'd0);
      chk("d1 count cleared by reset", cnt[1], 32'd0);
      cnt_m[1] = 32'd0;
      rst[1] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("d1 no ready after reset", 32'(rdy[1]), 32'd0);
      end
      access(1, 1, 0, 32'h80, 32'h0, 4'b1111, 0);

      // fill a small pool of words in each instance with known data
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 6; j++)
            access(i, 0, 1, 32'h100 + 32'(4 * j), $urandom, 4'b1111, 0);

      // randomized mix of reads, writes, illegal lanes and bad addresses
      for (int n = 0; n < 40; n++) begin
         d    = $urandom_range(0, 1);
         kind = $urandom_range(0, 9);
         a    = 32'h100 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 7) b = legal[$urandom_range(0, 6)];
         else                          b = 4'($urandom);
         case (kind)
            0, 1, 2, 3: access(d, 1, 0, a, 32'h0, b, d == 1);
            4, 5, 6, 7: access(d, 0, 1, a, $urandom, b, d == 1);
            8:          access(d, 1, 1, a, $urandom, b, d == 1);
            default:    access(d, 0, 1, 32'h4000 + 32'($urandom_range(0, 65535)),
                               $urandom, b, d == 1);
         endcase
      end

      // read back every pool word to expose any stray write
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 6; j++)
            access(i, 1, 0, 32'h100 + 32'(4 * j), 32'h0, 4'b1111, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
